// File: rtl/ysyx_24100006_gpr_sb.sv
// GPR file with per-register pending-write scoreboard for the NPC ID stage.
// Combinational read ports, one writeback port, optional WB->read bypass.
module ysyx_24100006_gpr_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2,
  parameter int CNT_WIDTH  = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NR_READ*ADDR_WIDTH-1:0] rs_addr,
  output logic [NR_READ*DATA_WIDTH-1:0] rs_data,
  output logic [NR_READ-1:0]            rs_ready,
  input  logic                          iss_valid,
  input  logic [ADDR_WIDTH-1:0]         iss_rd,
  output logic                          iss_ready,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          flush,
  output logic                          wb_err
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q   [NREG];
  logic [DATA_WIDTH-1:0] rf_d   [NREG];
  logic [CNT_WIDTH-1:0]  pend_q [NREG];
  logic [CNT_WIDTH-1:0]  pend_d [NREG];
  logic                  wb_err_q;
  logic                  wb_err_d;

  logic wr_en;
  logic iss_acc;
  logic ret;

  assign wr_en = wen && (waddr != '0);
  assign ret   = wr_en && (pend_q[waddr] != '0);

  // Ready uses the pre-update count, so a retire cannot unblock a full counter.
  assign iss_ready = !flush &&
                     ((iss_rd == '0) || (pend_q[iss_rd] != '1));
  assign iss_acc   = iss_valid && iss_ready && (iss_rd != '0);

  assign wb_err = wb_err_q;

  for (genvar g = 0; g < NR_READ; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit;

    assign ra  = rs_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit = BYPASS && wen && (waddr == ra);

    assign rs_data[g*DATA_WIDTH +: DATA_WIDTH] =
      (hit && (ra != '0)) ? wdata : rf_q[ra];

    assign rs_ready[g] = (pend_q[ra] == '0) ||
                         (hit && (pend_q[ra] == CNT_WIDTH'(1)));
  end

  always_comb begin
    rf_d     = rf_q;
    pend_d   = pend_q;
    wb_err_d = wr_en && (pend_q[waddr] == '0);
    if (wr_en) rf_d[waddr] = wdata;
    // Issue and retire on the same register cancel out.
    for (int i = 1; i < NREG; i++) begin
      if (iss_acc && (iss_rd == ADDR_WIDTH'(i)))
        pend_d[i] = pend_d[i] + 1'b1;
      if (ret && (waddr == ADDR_WIDTH'(i)))
        pend_d[i] = pend_d[i] - 1'b1;
    end
    if (flush) pend_d = '{default: '0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q     <= '{default: '0};
      pend_q   <= '{default: '0};
      wb_err_q <= 1'b0;
    end else begin
      rf_q     <= rf_d;
      pend_q   <= pend_d;
      wb_err_q <= wb_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_gpr_sb.sv
// Bench for ysyx_24100006_gpr_sb: directed scenarios then random traffic,
// checked against an array-based model on a bypass and a no-bypass instance.
module tb_ysyx_24100006_gpr_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [NR*AW-1:0] rs_addr;
  logic [NR*DW-1:0] rs_data, rs_data_nb;
  logic [NR-1:0]  rs_ready, rs_ready_nb;
  logic           iss_valid;
  logic [AW-1:0]  iss_rd;
  logic           iss_ready, iss_ready_nb;
  logic           wen;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic           flush;
  logic           wb_err, wb_err_nb;

  ysyx_24100006_gpr_sb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR),
    .CNT_WIDTH(CW), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .rs_addr(rs_addr), .rs_data(rs_data), .rs_ready(rs_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .flush(flush), .wb_err(wb_err)
  );

  ysyx_24100006_gpr_sb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR),
    .CNT_WIDTH(CW), .BYPASS(1'b0)
  ) dut_nb (
    .clk(clk), .reset(reset),
    .rs_addr(rs_addr), .rs_data(rs_data_nb), .rs_ready(rs_ready_nb),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_nb),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .flush(flush), .wb_err(wb_err_nb)
  );

  logic [DW-1:0] m_rf [32];
  int            m_pend [32];
  logic          m_err;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] x_data(bit byp, int a);
    if (byp && wen && int'(waddr) == a && a != 0) return wdata;
    return m_rf[a];
  endfunction

  function automatic logic x_ready(bit byp, int a);
    return (m_pend[a] == 0) ||
           (byp && wen && int'(waddr) == a && m_pend[a] == 1);
  endfunction

  function automatic logic x_iss();
    return !flush && (iss_rd == 0 || m_pend[iss_rd] < CMAX);
  endfunction

  task automatic idle();
    reset = 1'b0; iss_valid = 1'b0; iss_rd = '0;
    wen = 1'b0; waddr = '0; wdata = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rs_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic look();
    int a;
    #2;
    for (int p = 0; p < NR; p++) begin
      a = int'(rs_addr[p*AW +: AW]);
      chk($sformatf("data%0d_x%0d", p, a),
          rs_data[p*DW +: DW], x_data(1'b1, a));
      chk($sformatf("nb_data%0d_x%0d", p, a),
          rs_data_nb[p*DW +: DW], x_data(1'b0, a));
      chk($sformatf("ready%0d_x%0d", p, a),
          32'(rs_ready[p]), 32'(x_ready(1'b1, a)));
      chk($sformatf("nb_ready%0d_x%0d", p, a),
          32'(rs_ready_nb[p]), 32'(x_ready(1'b0, a)));
    end
    chk("iss_ready", 32'(iss_ready), 32'(x_iss()));
    chk("nb_iss_ready", 32'(iss_ready_nb), 32'(x_iss()));
    chk("wb_err", 32'(wb_err), 32'(m_err));
    chk("nb_wb_err", 32'(wb_err_nb), 32'(m_err));
  endtask

  task automatic tick();
    logic acc;
    logic e;
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_rf[r] = '0;
        m_pend[r] = 0;
      end
      m_err = 1'b0;
    end else begin
      acc = iss_valid && x_iss() && iss_rd != 0;
      e = 1'b0;
      if (wen && waddr != 0) begin
        m_rf[waddr] = wdata;
        if (m_pend[waddr] == 0) e = 1'b1;
        else m_pend[waddr]--;
      end
      if (acc) m_pend[iss_rd]++;
      if (flush)
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
      m_err = e;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    set_rd(0, 0);
    reset = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0;

    // 1: post-reset contents, then a write seen next cycle
    for (int r = 1; r < 32; r += 2) begin
      set_rd(r, r + 1);
      look();
      chk("t1_zero", rs_data[31:0], 32'h0);
      chk("t1_rdy", 32'(rs_ready), 32'h3);
      tick();
    end
    wen = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
    set_rd(1, 2);
    look();
    tick();
    idle();
    set_rd(5, 5);
    look();
    chk("t1_x5", rs_data[31:0], 32'hDEADBEEF);
    chk("t1_x5_nb", rs_data_nb[63:32], 32'hDEADBEEF);
    tick();

    // 2: x0 is hard-wired
    wen = 1'b1; waddr = 0; wdata = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_rd = 0;
    set_rd(0, 0);
    look();
    chk("t2_x0_byp", rs_data[31:0], 32'h0);
    chk("t2_iss0", 32'(iss_ready), 32'h1);
    tick();
    idle();
    look();
    chk("t2_x0", rs_data[31:0], 32'h0);
    chk("t2_rdy0", 32'(rs_ready[0]), 32'h1);
    chk("t2_noerr", 32'(wb_err), 32'h0);
    tick();

    // 3: RAW hazard and bypass
    iss_valid = 1'b1; iss_rd = 7;
    look();
    tick();
    idle();
    set_rd(7, 7);
    look();
    chk("t3_busy", 32'(rs_ready[0]), 32'h0);
    chk("t3_busy_nb", 32'(rs_ready_nb[1]), 32'h0);
    tick();
    wen = 1'b1; waddr = 7; wdata = 32'h1234;
    look();
    chk("t3_byp_rdy", 32'(rs_ready[0]), 32'h1);
    chk("t3_byp_data", rs_data[31:0], 32'h1234);
    chk("t3_nb_rdy", 32'(rs_ready_nb[0]), 32'h0);
    chk("t3_nb_data", rs_data_nb[31:0], 32'h0);
    tick();
    idle();
    look();
    chk("t3_nb_rdy2", 32'(rs_ready_nb[0]), 32'h1);
    chk("t3_nb_data2", rs_data_nb[31:0], 32'h1234);
    tick();

    // 4: counter saturation
    iss_valid = 1'b1; iss_rd = 3;
    set_rd(3, 0);
    for (int k = 0; k < 3; k++) begin
      look();
      chk("t4_acc", 32'(iss_ready), 32'h1);
      tick();
    end
    look();
    chk("t4_sat", 32'(iss_ready), 32'h0);
    tick();
    wen = 1'b1; waddr = 3; wdata = 32'h33;
    look();
    chk("t4_sat_ret", 32'(iss_ready), 32'h0);
    tick();
    wen = 1'b0;
    look();
    chk("t4_reacc", 32'(iss_ready), 32'h1);
    tick();
    iss_valid = 1'b0;
    look();
    chk("t4_full", 32'(iss_ready), 32'h0);
    tick();
    wen = 1'b1; waddr = 3;
    for (int k = 0; k < 3; k++) begin
      wdata = 32'(k);
      look();
      tick();
    end
    idle();
    look();
    chk("t4_drained", 32'(rs_ready[0]), 32'h1);
    chk("t4_noerr", 32'(wb_err), 32'h0);
    tick();

    // 5: flush
    iss_valid = 1'b1; iss_rd = 4;
    look();
    tick();
    iss_rd = 9;
    look();
    tick();
    idle();
    flush = 1'b1; wen = 1'b1; waddr = 4; wdata = 32'h55;
    iss_valid = 1'b1; iss_rd = 12;
    look();
    chk("t5_flush_iss", 32'(iss_ready), 32'h0);
    tick();
    idle();
    set_rd(4, 9);
    look();
    chk("t5_rdy", 32'(rs_ready), 32'h3);
    chk("t5_x4", rs_data_nb[31:0], 32'h55);
    chk("t5_noerr", 32'(wb_err), 32'h0);
    tick();
    wen = 1'b1; waddr = 9; wdata = 32'h99;
    look();
    tick();
    idle();
    look();
    chk("t5_err", 32'(wb_err), 32'h1);
    tick();
    look();
    chk("t5_err_clr", 32'(wb_err), 32'h0);
    tick();

    // 6: reset beats a same-cycle writeback
    iss_valid = 1'b1; iss_rd = 6;
    look();
    tick();
    look();
    tick();
    idle();
    reset = 1'b1; wen = 1'b1; waddr = 6; wdata = 32'h66;
    look();
    tick();
    idle();
    set_rd(6, 5);
    look();
    chk("t6_x6", rs_data[31:0], 32'h0);
    chk("t6_x5", rs_data[63:32], 32'h0);
    chk("t6_rdy", 32'(rs_ready), 32'h3);
    chk("t6_err", 32'(wb_err), 32'h0);
    tick();

    // random traffic, biased to few registers to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 249) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rd    = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 31))
                                              : AW'($urandom_range(0, 5));
      wen       = $urandom_range(0, 1) == 1;
      waddr     = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 31))
                                              : AW'($urandom_range(0, 5));
      wdata     = $urandom;
      set_rd($urandom_range(0, 6), $urandom_range(0, 6));
      look();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
